// File: rtl/systolic_grid_seq.sv
// systolic_grid_seq: weight-stationary ROWS x COLS MAC array with input skew, output deskew and load/stream/drain control.
// Latency: a vector accepted at edge k shows on out_* after edge k+ROWS+COLS; one vector per cycle.
// Backpressure: none on the output side; input is gated only by in_ready (high in STREAM), the array never stalls.
module systolic_grid_seq #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int SIGNED       = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_load,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [COLS*DATA_WIDTH-1:0]   w_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [COLS*RESULT_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic                         done
);
  localparam int RCW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DCW  = $clog2(ROWS + COLS);
  localparam int TAGD = ROWS + COLS;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t                  state;
  logic [RCW-1:0]          row_cnt;
  logic [DCW-1:0]          drain_cnt;

  logic [DATA_WIDTH-1:0]   w_mem    [ROWS][COLS];
  logic [DATA_WIDTH-1:0]   skew_out [ROWS];
  logic [DATA_WIDTH-1:0]   act_in   [ROWS][COLS];
  logic [DATA_WIDTH-1:0]   act_q    [ROWS][COLS-1];
  logic [RESULT_WIDTH-1:0] sum_in   [ROWS][COLS];
  logic [RESULT_WIDTH-1:0] sum_q    [ROWS][COLS];
  logic [RESULT_WIDTH-1:0] desk_out [COLS];
  logic [COLS*RESULT_WIDTH-1:0] desk_flat;
  logic [1:0]              tag_q    [TAGD];  // {last, valid}

  logic                        accept;
  logic [ROWS*DATA_WIDTH-1:0]  inj_data;

  assign accept   = in_valid & in_ready;
  assign inj_data = accept ? in_data : '0;

  // Product widened to the accumulator before multiplying, so the sum wraps mod 2^RESULT_WIDTH.
  function automatic logic [RESULT_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) mul = RESULT_WIDTH'($signed(a)) * RESULT_WIDTH'($signed(b));
    else             mul = RESULT_WIDTH'(a) * RESULT_WIDTH'(b);
  endfunction

  // Controller: IDLE -> LOAD (ROWS weight beats) -> STREAM (until in_last) -> DRAIN (flush) -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      w_ready   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start_load) begin
          state   <= LOAD;
          row_cnt <= '0;
          w_ready <= 1'b1;
          busy    <= 1'b1;
        end
        LOAD: if (w_valid) begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == RCW'(ROWS - 1)) begin
            state    <= STREAM;
            w_ready  <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        STREAM: if (accept && in_last) begin
          state     <= DRAIN;
          in_ready  <= 1'b0;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          // Exits on the same edge the last result reaches out_data.
          if (drain_cnt == DCW'(ROWS + COLS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight store: beat k writes row k; contents persist until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_mem[r][c] <= '0;
    end else if (w_valid && w_ready) begin
      for (int c = 0; c < COLS; c++) w_mem[row_cnt][c] <= w_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk [r+1];
    // Row r is held r extra cycles so it meets the partial sum coming down from row r-1.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) sk[i] <= '0;
      end else begin
        sk[0] <= inj_data[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++) sk[i] <= sk[i-1];
      end
    end
    assign skew_out[r] = sk[r];
  end

  // Cell inputs: activations flow right along a row, partial sums flow down a column.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      act_in[r][0] = skew_out[r];
      for (int c = 1; c < COLS; c++) act_in[r][c] = act_q[r][c-1];
    end
    for (int c = 0; c < COLS; c++) sum_in[0][c] = '0;
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) sum_in[r][c] = sum_q[r-1][c];
  end

  // MAC cells: every cell advances every cycle, bubbles are simply zero operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) act_q[r][c] <= '0;
        for (int c = 0; c < COLS; c++) sum_q[r][c] <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) act_q[r][c] <= act_in[r][c];
        for (int c = 0; c < COLS; c++) sum_q[r][c] <= sum_in[r][c] + mul(act_in[r][c], w_mem[r][c]);
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_desk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign desk_out[c] = sum_q[ROWS-1][c];
    end else begin : g_dly
      logic [RESULT_WIDTH-1:0] dq [D];
      // Early columns wait for the rightmost column so the vector leaves aligned.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else begin
          dq[0] <= sum_q[ROWS-1][c];
          for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
        end
      end
      assign desk_out[c] = dq[D-1];
    end
  end

  // Flatten the aligned column sums.
  always_comb begin
    desk_flat = '0;
    for (int c = 0; c < COLS; c++) desk_flat[c*RESULT_WIDTH +: RESULT_WIDTH] = desk_out[c];
  end

  // Valid/last tags ride alongside the data with the same total delay; output holds its last valid value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAGD; i++) tag_q[i] <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      tag_q[0] <= {accept & in_last, accept};
      for (int i = 1; i < TAGD; i++) tag_q[i] <= tag_q[i-1];
      out_valid <= tag_q[TAGD-1][0];
      out_last  <= tag_q[TAGD-1][0] & tag_q[TAGD-1][1];
      if (tag_q[TAGD-1][0]) out_data <= desk_flat;
    end
  end
endmodule

// File: tb/tb_systolic_grid_seq.sv
`timescale 1ns/1ps
module tb_systolic_grid_seq;
  localparam int R = 4, C = 4, DW = 8;
  localparam int NR = 3, NC = 5;

  typedef logic [159:0] v_t;
  typedef struct packed {
    logic [127:0] es; logic [127:0] eu; logic [63:0] ew; logic last; logic [31:0] cyc;
  } exp_t;
  typedef struct packed { logic [159:0] d; logic last; logic [31:0] cyc; } expn_t;
  typedef struct packed {
    logic [127:0] wf; logic [31:0] af; logic [127:0] es; logic [127:0] eu; logic [63:0] ew;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // 4x4 group: three instances sharing inputs (signed/32, unsigned/32, signed/16)
  logic start_load = 0, w_valid = 0, in_valid = 0, in_last = 0;
  logic [C*DW-1:0] w_data = '0;
  logic [R*DW-1:0] in_data = '0;
  logic s_w_ready, s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic u_w_ready, u_in_ready, u_out_valid, u_out_last, u_busy, u_done;
  logic x_w_ready, x_in_ready, x_out_valid, x_out_last, x_busy, x_done;
  logic [127:0] s_out_data, u_out_data;
  logic [63:0]  x_out_data;

  // 3x5 instance
  logic n_start = 0, n_wv = 0, n_iv = 0, n_il = 0;
  logic [NC*DW-1:0] n_wd = '0;
  logic [NR*DW-1:0] n_id = '0;
  logic n_wr, n_ir, n_ov, n_ol, n_busy, n_done;
  logic [NC*32-1:0] n_od;

  systolic_grid_seq #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .RESULT_WIDTH(32), .SIGNED(1)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .w_valid(w_valid), .w_ready(s_w_ready),
    .w_data(w_data), .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(s_out_valid), .out_last(s_out_last), .out_data(s_out_data), .busy(s_busy), .done(s_done));
  systolic_grid_seq #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .RESULT_WIDTH(32), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .start_load(start_load), .w_valid(w_valid), .w_ready(u_w_ready),
    .w_data(w_data), .in_valid(in_valid), .in_ready(u_in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(u_out_valid), .out_last(u_out_last), .out_data(u_out_data), .busy(u_busy), .done(u_done));
  systolic_grid_seq #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .RESULT_WIDTH(16), .SIGNED(1)) dut_w (
    .clk(clk), .reset(reset), .start_load(start_load), .w_valid(w_valid), .w_ready(x_w_ready),
    .w_data(w_data), .in_valid(in_valid), .in_ready(x_in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(x_out_valid), .out_last(x_out_last), .out_data(x_out_data), .busy(x_busy), .done(x_done));
  systolic_grid_seq #(.ROWS(NR), .COLS(NC), .DATA_WIDTH(DW), .RESULT_WIDTH(32), .SIGNED(1)) dut_n (
    .clk(clk), .reset(reset), .start_load(n_start), .w_valid(n_wv), .w_ready(n_wr),
    .w_data(n_wd), .in_valid(n_iv), .in_ready(n_ir), .in_last(n_il), .in_data(n_id),
    .out_valid(n_ov), .out_last(n_ol), .out_data(n_od), .busy(n_busy), .done(n_done));

  logic [7:0] wm [R][C];
  logic [7:0] wn [NR][NC];
  exp_t  q[$];
  expn_t qn[$];
  vec_t  tbl[5];

  task automatic chk(input string nm, input bit ok, input v_t act, input v_t req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic last, input int at);
    exp_t e;
    e = '0;
    e.last = last;
    e.cyc = 32'(at);
    for (int c = 0; c < C; c++) begin
      int s;
      int unsigned u;
      s = 0;
      u = 0;
      for (int r = 0; r < R; r++) begin
        s += int'($signed(a[r*8 +: 8])) * int'($signed(wm[r][c]));
        u += int'(a[r*8 +: 8]) * int'(wm[r][c]);
      end
      e.es[c*32 +: 32] = s;
      e.eu[c*32 +: 32] = u;
      e.ew[c*16 +: 16] = s[15:0];
    end
    return e;
  endfunction

  function automatic expn_t model_n(input logic [23:0] a, input logic last, input int at);
    expn_t e;
    e = '0;
    e.last = last;
    e.cyc = 32'(at);
    for (int c = 0; c < NC; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < NR; r++) s += int'($signed(a[r*8 +: 8])) * int'($signed(wn[r][c]));
      e.d[c*32 +: 32] = s;
    end
    return e;
  endfunction

  // Scoreboard: compare every output beat against the queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    expn_t en;
    if (s_out_valid || u_out_valid || x_out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 1'b0, v_t'({s_out_valid, u_out_valid, x_out_valid}), v_t'(0));
      else begin
        e = q.pop_front();
        chk("out_cycle", cyc == int'(e.cyc), v_t'(cyc), v_t'(e.cyc));
        chk("out_signed32", s_out_valid && s_out_data == e.es, v_t'(s_out_data), v_t'(e.es));
        chk("out_unsigned32", u_out_valid && u_out_data == e.eu, v_t'(u_out_data), v_t'(e.eu));
        chk("out_wrap16", x_out_valid && x_out_data == e.ew, v_t'(x_out_data), v_t'(e.ew));
        chk("out_last", {s_out_last, u_out_last, x_out_last} == {3{e.last}},
            v_t'({s_out_last, u_out_last, x_out_last}), v_t'({3{e.last}}));
      end
    end
    if (n_ov) begin
      if (qn.size() == 0) chk("unexpected_out_3x5", 1'b0, v_t'(n_ov), v_t'(0));
      else begin
        en = qn.pop_front();
        chk("out_3x5_cycle", cyc == int'(en.cyc), v_t'(cyc), v_t'(en.cyc));
        chk("out_3x5_data", n_od == en.d && n_ol == en.last, v_t'(n_od), v_t'(en.d));
      end
    end
  end

  task automatic check_zero(input string nm);
    logic [23:0] ctl;
    ctl = {s_w_ready, s_in_ready, s_out_valid, s_out_last, s_busy, s_done,
           u_w_ready, u_in_ready, u_out_valid, u_out_last, u_busy, u_done,
           x_w_ready, x_in_ready, x_out_valid, x_out_last, x_busy, x_done,
           n_wr, n_ir, n_ov, n_ol, n_busy, n_done};
    chk({nm, "_ctrl"}, ctl == '0, v_t'(ctl), v_t'(0));
    chk({nm, "_data_s"}, s_out_data == '0, v_t'(s_out_data), v_t'(0));
    chk({nm, "_data_u"}, u_out_data == '0, v_t'(u_out_data), v_t'(0));
    chk({nm, "_data_w"}, x_out_data == '0, v_t'(x_out_data), v_t'(0));
    chk({nm, "_data_n"}, n_od == '0, v_t'(n_od), v_t'(0));
  endtask

  task automatic load_w(input logic [R*C*DW-1:0] wf);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = wf[(r*C+c)*DW +: DW];
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    chk("load_ready", s_w_ready && !s_in_ready && s_busy, v_t'({s_w_ready, s_in_ready, s_busy}), v_t'(3'b101));
    for (int k = 0; k < R; k++) begin
      int t;
      t = 0;
      w_data = wf[k*C*DW +: C*DW];
      w_valid = 1'b1;
      while (!s_w_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (!s_w_ready) chk("load_beat_timeout", 1'b0, v_t'(k), v_t'(R));
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    chk("stream_ready", s_in_ready && !s_w_ready, v_t'({s_in_ready, s_w_ready}), v_t'(2'b10));
  endtask

  task automatic send(input logic v, input logic [31:0] a, input logic last, output int acc);
    in_valid = v;
    in_data = a;
    in_last = last;
    acc = (v && s_in_ready) ? cyc + 1 : -1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string nm);
    int t;
    t = 0;
    while (!s_done && t < 60) begin @(posedge clk); #1; t++; end
    chk(nm, s_done && cyc == exp_cyc, v_t'(cyc), v_t'(exp_cyc));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, !s_done && !s_busy && !s_w_ready, v_t'({s_done, s_busy, s_w_ready}), v_t'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc, last_acc;
    logic [127:0] t128;
    logic [31:0] a;
    bit pat [9];

    tbl[0] = '{wf: 128'h01000000_00010000_00000100_00000001, af: 32'h04030201,
               es: {32'd4, 32'd3, 32'd2, 32'd1}, eu: {32'd4, 32'd3, 32'd2, 32'd1},
               ew: {16'd4, 16'd3, 16'd2, 16'd1}};
    tbl[1] = '{wf: {16{8'hFF}}, af: {4{8'h80}}, es: {4{32'd512}}, eu: {4{32'd130560}}, ew: {4{16'd512}}};
    tbl[2] = '{wf: {16{8'h7F}}, af: {4{8'h7F}}, es: {4{32'd64516}}, eu: {4{32'd64516}}, ew: {4{16'hFC04}}};
    tbl[3] = '{wf: {16{8'h01}}, af: 32'h04030201, es: {4{32'd10}}, eu: {4{32'd10}}, ew: {4{16'd10}}};
    tbl[4] = '{wf: {16{8'h01}}, af: 32'hFCFDFEFF, es: {4{32'hFFFFFFF6}}, eu: {4{32'd1014}}, ew: {4{16'hFFF6}}};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven single vectors with known results
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      load_w(tbl[i].wf);
      send(1'b1, tbl[i].af, 1'b1, acc);
      e.es = tbl[i].es; e.eu = tbl[i].eu; e.ew = tbl[i].ew; e.last = 1'b1; e.cyc = 32'(acc + R + C);
      if (acc >= 0) q.push_back(e);
      else chk("table_accept", 1'b0, v_t'(0), v_t'(1));
      wait_done(acc + R + C, "table_done");
    end

    // bubbly stream against the model, with control pokes in STREAM and DRAIN
    t128 = {$urandom, $urandom, $urandom, $urandom};
    load_w(t128);
    start_load = 1'b1;
    send(1'b0, 32'h0, 1'b0, acc);
    start_load = 1'b0;
    chk("start_in_stream_ignored", s_in_ready && !s_w_ready, v_t'({s_in_ready, s_w_ready}), v_t'(2'b10));
    pat = '{1, 1, 0, 1, 0, 0, 1, 1, 1};
    last_acc = 0;
    for (int i = 0; i < 9; i++) begin
      a = $urandom;
      send(pat[i], a, i == 8, acc);
      if (acc >= 0) begin q.push_back(model(a, i == 8, acc + R + C)); last_acc = acc; end
    end
    chk("bubble_accepts", q.size() == 6, v_t'(q.size()), v_t'(6));
    chk("drain_ready", !s_in_ready && !s_w_ready && s_busy, v_t'({s_in_ready, s_w_ready, s_busy}), v_t'(3'b001));
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    wait_done(last_acc + R + C, "bubble_done");
    chk("bubble_queue_empty", q.size() == 0, v_t'(q.size()), v_t'(0));

    // 3x5 non-square instance, random weights and gappy stream
    t128 = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) wn[r][c] = t128[(r*NC+c)*8 +: 8];
    n_start = 1'b1;
    @(posedge clk); #1;
    n_start = 1'b0;
    for (int k = 0; k < NR; k++) begin
      for (int c = 0; c < NC; c++) n_wd[c*8 +: 8] = wn[k][c];
      n_wv = 1'b1;
      chk("n_w_ready", n_wr == 1'b1, v_t'(n_wr), v_t'(1));
      @(posedge clk); #1;
    end
    n_wv = 1'b0;
    chk("n_in_ready", n_ir && !n_wr, v_t'({n_ir, n_wr}), v_t'(2'b10));
    for (int i = 0; i < 10; i++) begin
      logic v;
      logic [23:0] na;
      v = (i == 9) ? 1'b1 : 1'($urandom_range(0, 1));
      na = 24'($urandom);
      n_iv = v; n_id = na; n_il = (i == 9);
      if (v && n_ir) begin qn.push_back(model_n(na, i == 9, cyc + 1 + NR + NC)); last_acc = cyc + 1; end
      @(posedge clk); #1;
    end
    n_iv = 1'b0; n_il = 1'b0;
    begin
      int t;
      t = 0;
      while (!n_done && t < 60) begin @(posedge clk); #1; t++; end
      chk("n_done", n_done && cyc == last_acc + NR + NC, v_t'(cyc), v_t'(last_acc + NR + NC));
    end
    @(posedge clk); #1;
    chk("n_queue_empty", qn.size() == 0, v_t'(qn.size()), v_t'(0));

    // async reset with three vectors in flight
    t128 = {$urandom, $urandom, $urandom, $urandom};
    load_w(t128);
    for (int i = 0; i < 3; i++) send(1'b1, $urandom, 1'b0, acc);
    reset = 1'b1;
    #1;
    check_zero("midstream_reset");
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("post_reset_idle", !s_busy && !s_out_valid, v_t'({s_busy, s_out_valid}), v_t'(0));
    load_w(tbl[0].wf);
    send(1'b1, tbl[0].af, 1'b0, acc);
    if (acc >= 0) q.push_back(model(tbl[0].af, 1'b0, acc + R + C));
    a = $urandom;
    send(1'b1, a, 1'b1, acc);
    if (acc >= 0) q.push_back(model(a, 1'b1, acc + R + C));
    wait_done(acc + R + C, "reload_done");
    chk("final_queue_empty", q.size() == 0, v_t'(q.size()), v_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
